// File: rtl/aes_sub_shift_iter_pkg.sv
// Shared definitions for the iterative SubBytes/ShiftRows stage:
// FSM state encoding, state byte indexing and the forward/inverse S-box tables.
package aes_sub_shift_iter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Forward S-box, entry 0x00 in the most significant byte.
   localparam logic [2047:0] SBOX_FWD = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Inverse S-box, entry 0x00 in the most significant byte.
   localparam logic [2047:0] SBOX_INV = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   // Byte position of state element (r,c): 4c + r.
   function automatic logic [3:0] idx(input logic [1:0] r, input logic [1:0] c);
      return {c, r};
   endfunction

   // Pick entry b out of a 256-byte table stored MSB-first.
   function automatic logic [7:0] tbl_byte(input logic [2047:0] tbl, input logic [7:0] b);
      logic [10:0] base;
      base = 11'd2047 - {b, 3'b000};
      return tbl[base -: 8];
   endfunction

   function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
      return tbl_byte(SBOX_FWD, b);
   endfunction

   function automatic logic [7:0] sbox_inv(input logic [7:0] b);
      return tbl_byte(SBOX_INV, b);
   endfunction

endpackage

// File: rtl/aes_sub_shift_iter_sbox.sv
// Single combinational S-box lane; INVERSE selects the decrypt table.
module aes_sbox #(
   parameter bit INVERSE = 1'b0
) (
   input  logic [7:0] din,
   output logic [7:0] dout
);
   import aes_sub_shift_iter_pkg::*;

   // Table lookup for the selected direction.
   always_comb begin
      if (INVERSE) begin
         dout = sbox_inv(din);
      end else begin
         dout = sbox_fwd(din);
      end
   end

endmodule

// File: rtl/aes_sub_shift_iter.sv
// Iterative SubBytes+ShiftRows (or inverse) stage. Four shared S-box lanes
// process one input column per cycle; the ShiftRows permutation is folded
// into where each lane result is written in the output register.
module aes_sub_shift_iter #(
   parameter bit INVERSE = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:127] data_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] data_out,
   output logic         busy
);
   import aes_sub_shift_iter_pkg::*;

   state_t       state;
   logic [1:0]   cnt;
   logic [0:127] in_reg;
   logic [0:127] out_reg;
   logic         out_valid_r;
   logic         busy_r;

   logic [7:0]   lane_in  [4];
   logic [7:0]   lane_out [4];
   logic [1:0]   dst_col  [4];

   // Select the bytes of column cnt for the lanes and the shifted destination column per row.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         lane_in[r] = in_reg[{idx(2'(r), cnt), 3'b000} +: 8];
         if (INVERSE) begin
            dst_col[r] = cnt + 2'(r);
         end else begin
            dst_col[r] = cnt - 2'(r);
         end
      end
   end

   genvar g;
   for (g = 0; g < 4; g++) begin : g_lane
      aes_sbox #(.INVERSE(INVERSE)) u_sbox (
         .din  (lane_in[g]),
         .dout (lane_out[g])
      );
   end

   // Control FSM plus the input/output state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= 2'd0;
         in_reg      <= 128'd0;
         out_reg     <= 128'd0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_reg <= data_in;
                  cnt    <= 2'd0;
                  busy_r <= 1'b1;
                  state  <= SUB;
               end
            end
            SUB: begin
               for (int r = 0; r < 4; r++) begin
                  out_reg[{idx(2'(r), dst_col[r]), 3'b000} +: 8] <= lane_out[r];
               end
               if (cnt == 2'd3) begin
                  cnt         <= 2'd0;
                  busy_r      <= 1'b0;
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end
            DONE: begin
               // Output is held until downstream takes it; a waiting block may follow immediately.
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  if (in_valid) begin
                     in_reg <= data_in;
                     cnt    <= 2'd0;
                     busy_r <= 1'b1;
                     state  <= SUB;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state       <= IDLE;
               cnt         <= 2'd0;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   // Accept new data when idle, or in DONE only when the result leaves this cycle.
   always_comb begin
      case (state)
         IDLE:    in_ready = 1'b1;
         DONE:    in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
   end

   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign data_out  = out_reg;

endmodule

// File: tb/tb_aes_sub_shift_iter.sv
// Directed scoreboard bench for aes_sub_shift_iter, forward and inverse instances.
module tb_aes_sub_shift_iter;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid_f, in_valid_i;
   logic         out_ready_f, out_ready_i;
   logic [0:127] data_in_f, data_in_i;
   logic         in_ready_f, in_ready_i;
   logic         out_valid_f, out_valid_i;
   logic         busy_f, busy_i;
   logic [0:127] data_out_f, data_out_i;

   int n_cmp = 0;
   int n_mis = 0;
   logic [127:0] exp_q [$];

   localparam logic [127:0] V1 = 128'h00102030405060708090a0b0c0d0e0f0;
   localparam logic [127:0] E1 = 128'h6353e08c0960e104cd70b751bacad0e7;
   localparam logic [127:0] V2 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] E2 = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

   aes_sub_shift_iter #(.INVERSE(1'b0)) dut_f (
      .clk(clk), .rst(rst), .in_valid(in_valid_f), .in_ready(in_ready_f),
      .data_in(data_in_f), .out_valid(out_valid_f), .out_ready(out_ready_f),
      .data_out(data_out_f), .busy(busy_f)
   );

   aes_sub_shift_iter #(.INVERSE(1'b1)) dut_i (
      .clk(clk), .rst(rst), .in_valid(in_valid_i), .in_ready(in_ready_i),
      .data_in(data_in_i), .out_valid(out_valid_i), .out_ready(out_ready_i),
      .data_out(data_out_i), .busy(busy_i)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input string tag, input logic [127:0] obs);
      logic [127:0] e;
      if (exp_q.size() == 0) begin
         chk({tag, "_q_empty"}, 128'd1, 128'd0);
      end else begin
         e = exp_q.pop_front();
         chk(tag, obs, e);
      end
   endtask

   // Count cycles until out_valid of the chosen instance rises, bounded by budget.
   task automatic wait_valid(input bit inv, input int budget, output int lat);
      lat = 0;
      while (!(inv ? out_valid_i : out_valid_f) && lat < budget) begin
         tick();
         lat++;
      end
   endtask

   // Single isolated block with out_ready held high.
   task automatic run_block(input bit inv, input logic [127:0] d, input logic [127:0] e,
                            input string tag);
      int lat;
      if (inv) begin
         in_valid_i = 1'b1; data_in_i = d; out_ready_i = 1'b1;
      end else begin
         in_valid_f = 1'b1; data_in_f = d; out_ready_f = 1'b1;
      end
      exp_q.push_back(e);
      tick();
      in_valid_i = 1'b0;
      in_valid_f = 1'b0;
      chk({tag, "_busy"}, 128'(inv ? busy_i : busy_f), 128'd1);
      wait_valid(inv, 10, lat);
      chk({tag, "_latency"}, 128'(lat), 128'd4);
      pop_chk({tag, "_data"}, inv ? data_out_i : data_out_f);
      tick();
      chk({tag, "_valid_1cyc"}, 128'(inv ? out_valid_i : out_valid_f), 128'd0);
      chk({tag, "_in_ready_idle"}, 128'(inv ? in_ready_i : in_ready_f), 128'd1);
   endtask

   initial begin
      int lat;
      rst = 1'b1;
      in_valid_f = 1'b0; in_valid_i = 1'b0;
      out_ready_f = 1'b0; out_ready_i = 1'b0;
      data_in_f = 128'd0; data_in_i = 128'd0;
      tick();
      tick();
      chk("rst_out_valid", 128'(out_valid_f), 128'd0);
      chk("rst_data_out", data_out_f, 128'd0);
      chk("rst_busy", 128'(busy_f), 128'd0);
      rst = 1'b0;
      tick();
      chk("rst_in_ready", 128'(in_ready_f), 128'd1);

      // Known-answer vectors, forward and inverse.
      run_block(1'b0, V1, E1, "fwd_v1");
      run_block(1'b0, V2, E2, "fwd_v2");
      run_block(1'b1, E1, V1, "inv_v1");
      run_block(1'b1, E2, V2, "inv_v2");

      // Backpressure: result held for 10 cycles while a competing in_valid is ignored.
      out_ready_f = 1'b0;
      in_valid_f = 1'b1;
      data_in_f = V1;
      exp_q.push_back(E1);
      tick();
      in_valid_f = 1'b0;
      wait_valid(1'b0, 10, lat);
      chk("bp_latency", 128'(lat), 128'd4);
      in_valid_f = 1'b1;
      data_in_f = E1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_out_valid", 128'(out_valid_f), 128'd1);
         chk("bp_data_hold", data_out_f, exp_q[0]);
         chk("bp_in_ready", 128'(in_ready_f), 128'd0);
      end
      data_in_f = V2;
      out_ready_f = 1'b1;
      #1;
      chk("bp_in_ready_release", 128'(in_ready_f), 128'd1);
      pop_chk("bp_data_first", data_out_f);
      exp_q.push_back(E2);
      tick();
      in_valid_f = 1'b0;
      chk("bp_accept_busy", 128'(busy_f), 128'd1);
      chk("bp_accept_valid", 128'(out_valid_f), 128'd0);
      wait_valid(1'b0, 10, lat);
      chk("bp_second_latency", 128'(lat), 128'd4);
      pop_chk("bp_data_second", data_out_f);
      tick();

      // Back-to-back streaming: results 5 cycles apart.
      in_valid_f = 1'b1;
      out_ready_f = 1'b1;
      data_in_f = V1;
      exp_q.push_back(E1);
      tick();
      data_in_f = V2;
      exp_q.push_back(E2);
      wait_valid(1'b0, 10, lat);
      chk("b2b_first_latency", 128'(lat), 128'd4);
      pop_chk("b2b_first_data", data_out_f);
      tick();
      in_valid_f = 1'b0;
      chk("b2b_accept_busy", 128'(busy_f), 128'd1);
      wait_valid(1'b0, 10, lat);
      chk("b2b_gap", 128'(lat + 1), 128'd5);
      pop_chk("b2b_second_data", data_out_f);
      tick();
      chk("b2b_none_pending", 128'(exp_q.size()), 128'd0);

      // Asynchronous reset with cnt=2 discards the block; no expectation is queued for it.
      in_valid_f = 1'b1;
      data_in_f = V2;
      tick();
      in_valid_f = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 128'(out_valid_f), 128'd0);
      chk("mid_rst_data_out", data_out_f, 128'd0);
      chk("mid_rst_busy", 128'(busy_f), 128'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("mid_rst_in_ready", 128'(in_ready_f), 128'd1);
      run_block(1'b0, V1, E1, "post_rst_v1");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
